// File: rtl/pacoblaze_intc_pkg.sv
// Shared definitions for the pacoblaze3 interrupt controller:
// register offsets within the port window and the sequencer states.
package pacoblaze_intc_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [2:0] INTC_PENDING = 3'd0;
    localparam logic [2:0] INTC_MASK    = 3'd1;
    localparam logic [2:0] INTC_VECTOR  = 3'd2;
    localparam logic [2:0] INTC_EOI     = 3'd3;
    localparam logic [2:0] INTC_EDGE    = 3'd4;

    // Interrupt sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

endpackage

// File: rtl/pacoblaze_intc_if.sv
// Core-side bundle between a pacoblaze3 and its interrupt controller:
// port bus (address, strobes, write data, read data) plus interrupt/ack pair.
interface pacoblaze_intc_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] rd_data;
    logic       interrupt;
    logic       interrupt_ack;

    // The processor core drives the bus and acknowledges
    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  rd_data, interrupt
    );

    // The interrupt controller decodes the bus and raises interrupts
    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output rd_data, interrupt
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module intc_prio_enc #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [2:0]      idx
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        any = |req;
        idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pacoblaze_intc.sv
// Interrupt controller for a pacoblaze3 core. Synchronises NSRC request
// lines, latches them as edge or level requests, and sequences one
// interrupt at a time through IDLE -> REQ -> SERVICE with an EOI write.
module pacoblaze_intc
    import pacoblaze_intc_pkg::*;
#(
    parameter int         NSRC        = 8,
    parameter logic [7:0] BASE_ADDR   = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    pacoblaze_intc_if.slave bus
);

    localparam logic [7:0] ADDR_PENDING = BASE_ADDR + 8'(INTC_PENDING);
    localparam logic [7:0] ADDR_MASK    = BASE_ADDR + 8'(INTC_MASK);
    localparam logic [7:0] ADDR_VECTOR  = BASE_ADDR + 8'(INTC_VECTOR);
    localparam logic [7:0] ADDR_EOI     = BASE_ADDR + 8'(INTC_EOI);
    localparam logic [7:0] ADDR_EDGE    = BASE_ADDR + 8'(INTC_EDGE);

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_reg;
    logic [NSRC-1:0] synced;
    logic [NSRC-1:0] synced_prev_reg;
    logic [NSRC-1:0] rise;

    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] edge_reg;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] ack_clear;

    logic            any_active;
    logic [2:0]      act_idx;
    logic            take_ack;

    intc_state_t     state_reg, state_next;
    logic            vec_valid_reg, vec_valid_next;
    logic [2:0]      vec_idx_reg, vec_idx_next;

    logic            wr_pending, wr_mask, wr_eoi, wr_edge;
    logic            unused_read_strobe;

    // Reads have no side effects, so the read qualifier is not needed
    assign unused_read_strobe = bus.read_strobe;

    assign wr_pending = bus.write_strobe && (bus.port_id == ADDR_PENDING);
    assign wr_mask    = bus.write_strobe && (bus.port_id == ADDR_MASK);
    assign wr_eoi     = bus.write_strobe && (bus.port_id == ADDR_EOI);
    assign wr_edge    = bus.write_strobe && (bus.port_id == ADDR_EDGE);

    // Synchroniser chain per source plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg        <= '0;
            synced_prev_reg <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_reg[0]     <= src;
            synced_prev_reg <= synced;
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];
    assign rise   = synced & ~synced_prev_reg;
    assign active = pending_reg & mask_reg;

    intc_prio_enc #(.NSRC(NSRC)) u_prio (
        .req (active),
        .any (any_active),
        .idx (act_idx)
    );

    // A genuine acknowledge retires the winning edge request
    assign take_ack  = (state_reg == REQ) && bus.interrupt_ack && any_active;
    assign ack_clear = take_ack ? (NSRC'(1) << act_idx) : '0;

    // Per-source pending update: edge sources latch rises (a new rise beats
    // a same-cycle clear), level sources simply track the synced line
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign pending_next[gi] = edge_reg[gi]
                ? ((pending_reg[gi] & ~(wr_pending & bus.out_port[gi]) & ~ack_clear[gi]) | rise[gi])
                : synced[gi];
        end
    endgenerate

    // Configuration and pending registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
            mask_reg    <= '0;
            edge_reg    <= '0;
        end else begin
            pending_reg <= pending_next;
            if (wr_mask) begin
                mask_reg <= bus.out_port[NSRC-1:0];
            end
            if (wr_edge) begin
                edge_reg <= bus.out_port[NSRC-1:0];
            end
        end
    end

    // Sequencer state and latched vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            vec_valid_reg <= 1'b0;
            vec_idx_reg   <= 3'd0;
        end else begin
            state_reg     <= state_next;
            vec_valid_reg <= vec_valid_next;
            vec_idx_reg   <= vec_idx_next;
        end
    end

    // Next-state and vector logic; one interrupt in flight, no nesting
    always_comb begin
        state_next     = state_reg;
        vec_valid_next = vec_valid_reg;
        vec_idx_next   = vec_idx_reg;
        case (state_reg)
            IDLE: begin
                if (any_active) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.interrupt_ack) begin
                    if (any_active) begin
                        vec_valid_next = 1'b1;
                        vec_idx_next   = act_idx;
                        state_next     = SERVICE;
                    end else begin
                        // Request vanished in the ack cycle: hand back an empty vector
                        vec_valid_next = 1'b0;
                        vec_idx_next   = 3'd0;
                        state_next     = IDLE;
                    end
                end else if (!any_active) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    vec_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The state register is the interrupt flop: high exactly while in REQ
    assign bus.interrupt = (state_reg == REQ);

    // Combinational register readback; undecoded addresses read zero
    always_comb begin
        bus.rd_data = 8'h00;
        case (bus.port_id)
            ADDR_PENDING: bus.rd_data = 8'(pending_reg);
            ADDR_MASK:    bus.rd_data = 8'(mask_reg);
            ADDR_VECTOR:  bus.rd_data = {vec_valid_reg, 4'b0000, vec_idx_reg};
            ADDR_EDGE:    bus.rd_data = 8'(edge_reg);
            default:      bus.rd_data = 8'h00;
        endcase
    end

endmodule
